hamming_dec_engine: RTL and testbench
=====================================

Name: hamming_dec_engine

Overview:
Hardware SECDED Hamming(16,11) decoder engine, the receive-side counterpart of the program-1 parity encoder.
- On a req pulse, reads COUNT 16-bit codewords from byte-wide data memory and corrects single-bit errors.
- Detects double errors and writes the recovered 11-bit messages back to memory, then pulses ack.
- Sits beside data memory under TopLevel, sharing the same req/ack start/done handshake.

Parameters:
SRC_BASE, 64, byte address of codeword 0 low byte; codeword i occupies SRC_BASE+2i (lo) and SRC_BASE+2i+1 (hi)
DST_BASE, 94, byte address of message 0 low byte; message i occupies DST_BASE+2i (lo) and DST_BASE+2i+1 (hi)
COUNT, 15, number of codewords per request
ADDR_W, 8, memory address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  start request, sampled only in IDLE
ack  out  1  one-cycle done pulse
mem_addr  out  ADDR_W  byte address for read or write
mem_rd_data  in  8  combinational read data for mem_addr
mem_wr_en  out  1  write strobe, memory writes on the rising edge
mem_wr_data  out  8  write data
n_single  out  8  codewords corrected (incl. p16-only errors) in the last run
n_double  out  8  codewords flagged uncorrectable in the last run

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE, ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, word index=0, n_single=0, n_double=0.
- Reset asserted mid-run: abort next edge, no further writes, no ack. Already-written bytes stay in memory.
- Codeword layout, cw[15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p16}. Bit k (1..15) is Hamming position k; bit 0 is the overall parity.
- Syndrome s[3:0] = XOR of k over all set cw[k], k=1..15. Overall parity P = ^cw.
- Error classes:
  - s=0, P=0: clean.
  - s=0, P=1: p16 error; data intact; single.
  - s!=0, P=1: flip cw[s]; single.
  - s!=0, P=0: double; data taken uncorrected.
- Output bytes:
  - lo = d[8:1].
  - hi = {flag_dbl, 4'b0, d[11:9]}, where flag_dbl=1 only for double errors.
  - Clean and single-error words therefore yield hi=8'b00000ddd.
- FSM: IDLE -> RD_LO -> RD_HI -> DECODE -> WR_LO -> WR_HI -> (RD_LO of next word | DONE) -> IDLE.
- Per-state actions:
  - IDLE: on req=1, clear n_single/n_double and index; go to RD_LO.
  - RD_LO: mem_addr=SRC_BASE+2i; register mem_rd_data as cw[7:0].
  - RD_HI: mem_addr=SRC_BASE+2i+1; register cw[15:8].
  - DECODE: register decoded data and flags; increment n_single or n_double (saturate at 255).
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, write lo.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, write hi. Then if i==COUNT-1 go to DONE, else i++ and go to RD_LO.
  - DONE: ack=1 for exactly one cycle.
- Latency: 5 cycles per word. ack rises 5*COUNT+1 edges after the req-sampling edge; this is 76 for COUNT=15.
- req while not IDLE is ignored. req held high through DONE starts a new run on the IDLE cycle following DONE.
- Address arithmetic wraps mod 2^ADDR_W.
- mem_wr_en is 0 in every state except WR_LO/WR_HI.
- Source and destination regions overlapping is legal. Each word is fully read before it is written.
- Counters hold their values after DONE until the next req or reset.

Decomposition:
- Package hamming_pkg:
  - state enum (IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE);
  - err_class enum (CLEAN, SINGLE, DOUBLE);
  - localparams CW_W=16, MSG_W=11.
- Sub-module hamming_secded_dec (combinational):
  - input cw[15:0];
  - outputs data[11:1], err_class, syndrome[3:0].
- The engine instantiates hamming_secded_dec once, and the bench reuses it as a reference model.

Test Plan:
1. Clean all-ones: codeword 0 = 16'hFFFF (mem[64]=FF, mem[65]=FF), req -> mem[94]=8'hFF, mem[95]=8'h07; n_single=0, n_double=0; ack on edge 76.
2. Single data error: d=0, cw=16'h0020 (bit 5 flipped) -> mem[94]=8'h00, mem[95]=8'h00, n_single=1.
3. p16-only error: cw=16'hFFFE -> lo=8'hFF, hi=8'h07, n_single=1.
4. Double error: cw=16'hFFF9 (bits 1,2 flipped; s=3, P=0) -> lo=8'hFF, hi=8'h87, n_double=1.
5. Full 15-word run with random single flips at positions 0..15 -> every output equals {5'b0, d_in}, n_single=15 minus count of flip-free words, ack exactly one cycle.
6. Assert reset at cycle 20 of a run -> ack never pulses, mem_wr_en=0 from the next edge. A fresh req afterwards completes normally and counters restart from 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and widths for the SECDED Hamming(16,11) decode engine.
package hamming_pkg;

  localparam int CW_W  = 16;
  localparam int MSG_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE,
    DOUBLE
  } err_class_e;

endpackage

// File: rtl/hamming_dec_engine_if.sv
// Start/done handshake, byte-wide memory port and run statistics of the decode engine.
interface hamming_dec_engine_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        n_single;
  logic [7:0]        n_double;

  modport master (
    input  req, mem_rd_data,
    output ack, mem_addr, mem_wr_en, mem_wr_data, n_single, n_double
  );

  modport slave (
    output req, mem_rd_data,
    input  ack, mem_addr, mem_wr_en, mem_wr_data, n_single, n_double
  );
endinterface

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED Hamming(16,11) decoder; cw[k] is Hamming position k, cw[0] is overall parity.
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [MSG_W:1]  data,
  output err_class_e      err_class,
  output logic [3:0]      syndrome
);

  logic parity;

  always_comb begin
    syndrome = '0;
    for (int k = 1; k < CW_W; k++) begin
      if (cw[k]) syndrome = syndrome ^ 4'(k);
    end
    parity    = ^cw;
    data      = {cw[15:9], cw[7:5], cw[3]};
    err_class = CLEAN;
    if (syndrome == 4'd0) begin
      if (parity) err_class = SINGLE;
    end else if (parity) begin
      err_class = SINGLE;
      // Only data positions need flipping; parity-position errors leave data intact.
      if (syndrome == 4'd3)
        data[1] = ~data[1];
      else if (syndrome inside {[4'd5:4'd7]})
        data[syndrome - 4'd3] = ~data[syndrome - 4'd3];
      else if (syndrome >= 4'd9)
        data[syndrome - 4'd4] = ~data[syndrome - 4'd4];
    end else begin
      err_class = DOUBLE;
    end
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// Reads COUNT codewords from byte memory, SECDED-decodes them and writes 11-bit messages back.
// Five cycles per word; ack pulses one cycle after DONE, 5*COUNT+1 edges after req is sampled.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 94,
  parameter int COUNT    = 15,
  parameter int ADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hamming_dec_engine_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

  state_e            state;
  logic [7:0]        idx;
  logic [7:0]        cw_lo;
  logic [7:0]        cw_hi;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              ack;
  logic [7:0]        n_single;
  logic [7:0]        n_double;

  logic [MSG_W:1]    dec_data;
  err_class_e        dec_class;
  logic [3:0]        syndrome_unused;

  hamming_secded_dec u_dec (
    .cw        ({cw_hi, cw_lo}),
    .data      (dec_data),
    .err_class (dec_class),
    .syndrome  (syndrome_unused)
  );

  function automatic logic [ADDR_W-1:0] byte_addr(input int base, input logic [7:0] i,
                                                  input logic hi);
    int a;
    a = base + 2 * int'(i) + int'(hi);
    return a[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cw_lo    <= '0;
      cw_hi    <= '0;
      hi_byte  <= '0;
      addr     <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      ack      <= 1'b0;
      n_single <= '0;
      n_double <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            n_single <= '0;
            n_double <= '0;
            idx      <= '0;
            addr     <= byte_addr(SRC_BASE, 8'd0, 1'b0);
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          cw_lo <= bus.mem_rd_data;
          addr  <= byte_addr(SRC_BASE, idx, 1'b1);
          state <= RD_HI;
        end
        RD_HI: begin
          cw_hi <= bus.mem_rd_data;
          state <= DECODE;
        end
        DECODE: begin
          wr_data <= dec_data[8:1];
          hi_byte <= {dec_class == DOUBLE, 4'b0000, dec_data[11:9]};
          if (dec_class == SINGLE && n_single != 8'hFF) n_single <= n_single + 8'd1;
          if (dec_class == DOUBLE && n_double != 8'hFF) n_double <= n_double + 8'd1;
          addr  <= byte_addr(DST_BASE, idx, 1'b0);
          wr_en <= 1'b1;
          state <= WR_LO;
        end
        WR_LO: begin
          addr    <= byte_addr(DST_BASE, idx, 1'b1);
          wr_data <= hi_byte;
          state   <= WR_HI;
        end
        WR_HI: begin
          wr_en <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + 8'd1;
            addr  <= byte_addr(SRC_BASE, idx + 8'd1, 1'b0);
            state <= RD_LO;
          end
        end
        DONE: begin
          ack   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack;
  assign bus.mem_addr    = addr;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_data = wr_data;
  assign bus.n_single    = n_single;
  assign bus.n_double    = n_double;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench: stimulus queues expected memory writes and done statistics, a monitor checks them.
module tb_hamming_dec_engine;
  import hamming_pkg::*;

  localparam int SRC = 64;
  localparam int DST = 94;
  localparam int CNT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hamming_dec_engine_if #(.ADDR_W(8)) bus ();

  hamming_dec_engine #(
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .COUNT    (CNT),
    .ADDR_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;

  // Reference decoder instance, used to sanity-check the bench's own encoder.
  logic [15:0] ref_cw = 16'h0000;
  logic [11:1] ref_data;
  err_class_e  ref_cls;
  logic [3:0]  ref_syn;
  hamming_secded_dec u_ref (.cw(ref_cw), .data(ref_data), .err_class(ref_cls), .syndrome(ref_syn));

  typedef struct packed {logic [7:0] addr; logic [7:0] dat;} wr_t;
  typedef struct packed {logic [7:0] ns; logic [7:0] nd;} done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  logic check_ack_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    if (check_ack_low) begin
      chk("ack width", int'(bus.ack), 0);
      check_ack_low = 1'b0;
    end
    if (bus.mem_wr_en) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious write: addr %0d data 0x%0h, none expected", bus.mem_addr,
                 bus.mem_wr_data);
      end else begin
        e = wr_q.pop_front();
        chk("write addr", int'(bus.mem_addr), int'(e.addr));
        chk("write data", int'(bus.mem_wr_data), int'(e.dat));
      end
    end
    if (bus.ack) begin
      check_ack_low = 1'b1;
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious ack at cycle %0d, none expected", cyc);
      end else begin
        d = done_q.pop_front();
        chk("n_single", int'(bus.n_single), int'(d.ns));
        chk("n_double", int'(bus.n_double), int'(d.nd));
        chk("ack latency", cyc - req_cyc, 5 * CNT + 1);
      end
    end
  end

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    logic [3:0]  s;
    c       = '0;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    s = '0;
    for (int k = 1; k < 16; k++) if (c[k]) s = s ^ 4'(k);
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic load(input int i, input logic [15:0] cw);
    mem[SRC + 2 * i]     = cw[7:0];
    mem[SRC + 2 * i + 1] = cw[15:8];
  endtask

  task automatic expect_word(input int i, input logic [7:0] lo, input logic [7:0] hi);
    wr_q.push_back('{addr: 8'(DST + 2 * i), dat: lo});
    wr_q.push_back('{addr: 8'(DST + 2 * i + 1), dat: hi});
  endtask

  task automatic start_run();
    @(posedge clk);
    #1 bus.req = 1'b1;
    req_cyc = cyc + 1;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      chk({name, " ack timeout"}, done_q.size(), 0);
      done_q.delete();
    end
    repeat (3) @(posedge clk);
    chk({name, " writes outstanding"}, wr_q.size(), 0);
    wr_q.delete();
  endtask

  logic [15:0] a_cw [8] = '{16'hFFFF, 16'h0020, 16'hFFFE, 16'hFFF9,
                            16'h000F, 16'h010F, 16'h0000, 16'h0003};
  logic [15:0] a_exp[8] = '{16'hFF07, 16'h0000, 16'hFF07, 16'hFF87,
                            16'h0100, 16'h0100, 16'h0000, 16'h0080};
  logic [10:0] a_dat[7] = '{11'h5A5, 11'h2AA, 11'h400, 11'h123, 11'h7FE, 11'h0F0, 11'h3C3};

  initial begin
    logic [10:0] d;
    logic [15:0] cw;
    int          f;
    int          ns_exp;

    bus.req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", int'(bus.ack), 0);
    chk("reset mem_wr_en", int'(bus.mem_wr_en), 0);
    chk("reset mem_addr", int'(bus.mem_addr), 0);
    chk("reset mem_wr_data", int'(bus.mem_wr_data), 0);
    chk("reset n_single", int'(bus.n_single), 0);
    chk("reset n_double", int'(bus.n_double), 0);
    reset = 1'b0;

    // Run A: clean, data-bit, p16-only, parity-bit and double errors, then clean words.
    for (int i = 0; i < 8; i++) begin
      load(i, a_cw[i]);
      expect_word(i, a_exp[i][15:8], a_exp[i][7:0]);
    end
    for (int i = 0; i < 7; i++) begin
      d = a_dat[i];
      load(8 + i, enc(d));
      expect_word(8 + i, d[7:0], {5'b00000, d[10:8]});
    end
    done_q.push_back('{ns: 8'd3, nd: 8'd2});
    start_run();
    wait_done("run A");

    // Run B: random data, random single flip at position 0..15 or none (16).
    ns_exp = 0;
    for (int i = 0; i < CNT; i++) begin
      d = 11'($urandom_range(0, 2047));
      f = int'($urandom_range(0, 16));
      cw = enc(d);
      ref_cw = cw;
      #1;
      chk("ref class", int'(ref_cls), int'(CLEAN));
      chk("ref data", int'(ref_data), int'(d));
      if (f < 16) begin
        cw[f] = ~cw[f];
        ns_exp++;
      end
      load(i, cw);
      expect_word(i, d[7:0], {5'b00000, d[10:8]});
    end
    done_q.push_back('{ns: 8'(ns_exp), nd: 8'd0});
    start_run();
    wait_done("run B");

    // Run C: reset sampled at edge 20 after req; words 0..3 are fully written before it.
    for (int i = 0; i < CNT; i++) begin
      d = 11'(i * 37 + 5);
      load(i, enc(d));
      if (i < 4) expect_word(i, d[7:0], {5'b00000, d[10:8]});
    end
    start_run();
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort n_single", int'(bus.n_single), 0);
    chk("abort mem_wr_en", int'(bus.mem_wr_en), 0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    chk("abort writes outstanding", wr_q.size(), 0);
    wr_q.delete();

    // Run D: fresh run after the abort, one p16-only error in word 0.
    for (int i = 0; i < CNT; i++) begin
      d = 11'(2047 - i * 91);
      cw = enc(d);
      if (i == 0) cw[0] = ~cw[0];
      load(i, cw);
      expect_word(i, d[7:0], {5'b00000, d[10:8]});
    end
    done_q.push_back('{ns: 8'd1, nd: 8'd0});
    start_run();
    wait_done("run D");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
